dmem_arbiter: RTL

Two-requester arbiter and access sequencer for the single-port data memory (`dmem`, byte-addressed, big-endian, `[0:31]` bit numbering).

- Shares `dmem` between requester 0 (processor load/store path) and requester 1 (loader/debug port) using a req/ack handshake and round-robin priority.
- Rejects misaligned, malformed and out-of-range accesses without touching memory.
- Sits between the requesters and the `dmem` instance and owns every `dmem` control input.

---
 rtl/dmem_pkg.sv | 40 ++++
 rtl/dmem_arbiter_if.sv | 36 +++
 rtl/dmem_access_check.sv | 27 ++
 rtl/dmem_arbiter.sv | 126 ++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter slice:
// arbiter FSM states, access-size decoding and the default memory capacity.
package dmem_pkg;

    localparam int unsigned DMEM_SIZE_DEFAULT = 16384;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SERVE,
        ST_ACK
    } arb_state_e;

    typedef enum logic [1:0] {
        SZ_WORD,
        SZ_HALF,
        SZ_BYTE,
        SZ_INVALID
    } access_size_e;

    function automatic access_size_e decodeSize(input logic byteSel, input logic halfSel);
        if (byteSel && halfSel) begin
            return SZ_INVALID;
        end else if (byteSel) begin
            return SZ_BYTE;
        end else if (halfSel) begin
            return SZ_HALF;
        end
        return SZ_WORD;
    endfunction

    // An invalid size is rejected on its own, so its byte count never matters.
    function automatic logic [2:0] sizeBytes(input access_size_e size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports and the dmem control/data lines.
// The arbiter uses the slave view; requesters plus the memory use the master view.
interface dmem_arbiter_if;

    logic        r0_req, r0_we, r0_byte, r0_half_word, r0_sign_extend;
    logic [0:31] r0_addr, r0_wdata;
    logic        r0_ack, r0_err;
    logic [0:31] r0_rdata;

    logic        r1_req, r1_we, r1_byte, r1_half_word, r1_sign_extend;
    logic [0:31] r1_addr, r1_wdata;
    logic        r1_ack, r1_err;
    logic [0:31] r1_rdata;

    logic [0:31] mem_addr, mem_data_in, mem_data_out;
    logic        mem_write_enable, mem_byte, mem_half_word, mem_sign_extend;

    modport slave (
        input  r0_req, r0_we, r0_byte, r0_half_word, r0_sign_extend, r0_addr, r0_wdata,
        output r0_ack, r0_err, r0_rdata,
        input  r1_req, r1_we, r1_byte, r1_half_word, r1_sign_extend, r1_addr, r1_wdata,
        output r1_ack, r1_err, r1_rdata,
        output mem_addr, mem_data_in, mem_write_enable, mem_byte, mem_half_word, mem_sign_extend,
        input  mem_data_out
    );

    modport master (
        output r0_req, r0_we, r0_byte, r0_half_word, r0_sign_extend, r0_addr, r0_wdata,
        input  r0_ack, r0_err, r0_rdata,
        output r1_req, r1_we, r1_byte, r1_half_word, r1_sign_extend, r1_addr, r1_wdata,
        input  r1_ack, r1_err, r1_rdata,
        input  mem_addr, mem_data_in, mem_write_enable, mem_byte, mem_half_word, mem_sign_extend,
        output mem_data_out
    );

endinterface

// File: rtl/dmem_access_check.sv
// Combinational access validator: flags malformed size, misalignment and
// any access whose last byte falls beyond the memory capacity.
module dmem_access_check
    import dmem_pkg::*;
#(
    parameter int unsigned SIZE = DMEM_SIZE_DEFAULT
) (
    input  logic        byteSel_i,
    input  logic        halfSel_i,
    input  logic [0:31] addr_i,
    output logic        bad_o
);

    access_size_e size;
    logic [32:0]  endAddr;
    logic         misaligned;

    // The end address is one bit wider so addresses near 2^32 cannot wrap into range.
    always_comb begin
        size       = decodeSize(byteSel_i, halfSel_i);
        endAddr    = {1'b0, addr_i} + {30'd0, sizeBytes(size)};
        misaligned = ((size == SZ_HALF) && addr_i[31])
                   || ((size == SZ_WORD) && (addr_i[30:31] != 2'b00));
        bad_o      = (size == SZ_INVALID) || misaligned || (endAddr > 33'(SIZE));
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin two-requester arbiter and one-access-per-three-cycles sequencer
// for the single-port data memory; owns every dmem control input.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned SIZE = DMEM_SIZE_DEFAULT
) (
    input logic           clock,
    input logic           reset,
    dmem_arbiter_if.slave bus
);

    arb_state_e  state_q;
    logic        gnt_q;
    logic        gnt_d;
    logic        bad_q;
    logic        lastGrant_q;
    logic [1:0]  ack_q;
    logic [1:0]  err_q;
    logic [0:31] rdata_q [2];

    logic        anyReq;
    logic        selGnt;
    logic        serving;
    logic        badNow;
    logic        selWe, selByte, selHalf, selSext;
    logic [0:31] selAddr, selWdata;

    // On a tie the requester that was not served last wins.
    always_comb begin
        anyReq = bus.r0_req | bus.r1_req;
        if (bus.r0_req && bus.r1_req) begin
            gnt_d = ~lastGrant_q;
        end else if (bus.r0_req) begin
            gnt_d = 1'b0;
        end else begin
            gnt_d = 1'b1;
        end
    end

    assign selGnt  = (state_q == ST_IDLE) ? gnt_d : gnt_q;
    assign serving = (state_q == ST_SERVE);

    always_comb begin
        if (selGnt) begin
            selWe    = bus.r1_we;
            selByte  = bus.r1_byte;
            selHalf  = bus.r1_half_word;
            selSext  = bus.r1_sign_extend;
            selAddr  = bus.r1_addr;
            selWdata = bus.r1_wdata;
        end else begin
            selWe    = bus.r0_we;
            selByte  = bus.r0_byte;
            selHalf  = bus.r0_half_word;
            selSext  = bus.r0_sign_extend;
            selAddr  = bus.r0_addr;
            selWdata = bus.r0_wdata;
        end
    end

    dmem_access_check #(
        .SIZE(SIZE)
    ) u_check (
        .byteSel_i(selByte),
        .halfSel_i(selHalf),
        .addr_i   (selAddr),
        .bad_o    (badNow)
    );

    // Memory controls are decoded from the state register so a reset mid-SERVE
    // withdraws the write enable immediately.
    assign bus.mem_addr         = serving ? selAddr  : '0;
    assign bus.mem_data_in      = serving ? selWdata : '0;
    assign bus.mem_byte         = serving & selByte;
    assign bus.mem_half_word    = serving & selHalf;
    assign bus.mem_sign_extend  = serving & selSext;
    assign bus.mem_write_enable = serving & selWe & ~bad_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            gnt_q       <= 1'b0;
            bad_q       <= 1'b0;
            lastGrant_q <= 1'b1;
            ack_q       <= '0;
            err_q       <= '0;
            rdata_q[0]  <= '0;
            rdata_q[1]  <= '0;
        end else begin
            ack_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (anyReq) begin
                        gnt_q   <= gnt_d;
                        bad_q   <= badNow;
                        state_q <= ST_SERVE;
                    end
                end
                ST_SERVE: begin
                    err_q[gnt_q] <= bad_q;
                    if (!selWe && !bad_q) begin
                        rdata_q[gnt_q] <= bus.mem_data_out;
                    end
                    lastGrant_q  <= gnt_q;
                    ack_q[gnt_q] <= 1'b1;
                    state_q      <= ST_ACK;
                end
                ST_ACK: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.r0_ack   = ack_q[0];
    assign bus.r1_ack   = ack_q[1];
    assign bus.r0_err   = err_q[0];
    assign bus.r1_err   = err_q[1];
    assign bus.r0_rdata = rdata_q[0];
    assign bus.r1_rdata = rdata_q[1];

endmodule
